// File: rtl/rgmii_rx_framer.sv
// RGMII receive framer: finds preamble/SFD and streams the payload bytes as AXI-Stream beats.
// Optional statistics outputs stat_good/stat_bad are built when RGMII_RX_FRAMER_STATS_EN is defined.
module rgmii_rx_framer #(
   parameter int unsigned MIN_PREAMBLE = 1,
   parameter int unsigned MAX_LEN      = 1518
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] rxd_q1,
   input  logic [3:0] rxd_q2,
   input  logic       rx_ctl_q1,
   input  logic       rx_ctl_q2,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   output logic       m_axis_tlast,
   output logic       m_axis_tuser,
   output logic       frame_good,
   output logic       frame_bad,
   output logic       preamble_err
`ifdef RGMII_RX_FRAMER_STATS_EN
   ,
   output logic [15:0] stat_good,
   output logic [15:0] stat_bad
`endif
);

   localparam int unsigned LEN_W  = 16;
   localparam int unsigned PRE_W  = 4;
   localparam int unsigned BYTE_W = 8;
   localparam logic [BYTE_W-1:0] PRE_BYTE = 8'h55;
   localparam logic [BYTE_W-1:0] SFD_BYTE = 8'hD5;
   localparam logic [PRE_W-1:0]  PRE_MAX  = '1;

   typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} state_t;

   state_t             state;
   logic [BYTE_W-1:0]  rx_byte;
   logic               rx_dv;
   logic               rx_er;
   logic [BYTE_W-1:0]  hold_byte;
   logic               hold_vld;
   logic               err;
   logic [LEN_W-1:0]   len_cnt;
   logic [PRE_W-1:0]   pre_cnt;

   // Stage 1: assemble the DDR nibbles and decode the ctl pair
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_byte <= '0;
         rx_dv   <= 1'b0;
         rx_er   <= 1'b0;
      end else begin
         rx_byte <= {rxd_q2, rxd_q1};
         rx_dv   <= rx_ctl_q1;
         rx_er   <= rx_ctl_q1 ^ rx_ctl_q2;
      end
   end

   // Framing FSM; each payload byte waits in the hold register so the last one can carry tlast
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         hold_byte     <= '0;
         hold_vld      <= 1'b0;
         err           <= 1'b0;
         len_cnt       <= '0;
         pre_cnt       <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
         frame_good    <= 1'b0;
         frame_bad     <= 1'b0;
         preamble_err  <= 1'b0;
      end else begin
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
         frame_good    <= 1'b0;
         frame_bad     <= 1'b0;
         preamble_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (rx_dv) begin
                  if (rx_byte == PRE_BYTE) begin
                     state   <= PREAMBLE;
                     pre_cnt <= PRE_W'(1);
                  end else if (rx_byte == SFD_BYTE && MIN_PREAMBLE == 0) begin
                     state <= PAYLOAD;
                  end else begin
                     state        <= DROP;
                     preamble_err <= 1'b1;
                  end
               end
            end
            PREAMBLE: begin
               if (!rx_dv) begin
                  preamble_err <= 1'b1;
                  state        <= IDLE;
                  err          <= 1'b0;
                  len_cnt      <= '0;
                  pre_cnt      <= '0;
                  hold_vld     <= 1'b0;
               end else if (rx_byte == PRE_BYTE) begin
                  if (pre_cnt != PRE_MAX) pre_cnt <= pre_cnt + PRE_W'(1);
               end else if (rx_byte == SFD_BYTE && 32'(pre_cnt) >= MIN_PREAMBLE) begin
                  state <= PAYLOAD;
               end else begin
                  preamble_err <= 1'b1;
                  state        <= DROP;
               end
            end
            PAYLOAD: begin
               if (!rx_dv) begin
                  if (hold_vld) begin
                     m_axis_tdata  <= hold_byte;
                     m_axis_tvalid <= 1'b1;
                     m_axis_tlast  <= 1'b1;
                     m_axis_tuser  <= err;
                     frame_good    <= ~err;
                     frame_bad     <= err;
                  end else begin
                     frame_bad <= 1'b1;
                  end
                  state    <= IDLE;
                  err      <= 1'b0;
                  len_cnt  <= '0;
                  pre_cnt  <= '0;
                  hold_vld <= 1'b0;
               end else if (32'(len_cnt) == MAX_LEN) begin
                  // one byte too many: close the frame as bad and discard the rest
                  m_axis_tdata  <= hold_byte;
                  m_axis_tvalid <= 1'b1;
                  m_axis_tlast  <= 1'b1;
                  m_axis_tuser  <= 1'b1;
                  frame_bad     <= 1'b1;
                  state         <= DROP;
               end else begin
                  if (hold_vld) begin
                     m_axis_tdata  <= hold_byte;
                     m_axis_tvalid <= 1'b1;
                  end
                  hold_byte <= rx_byte;
                  hold_vld  <= 1'b1;
                  len_cnt   <= len_cnt + LEN_W'(1);
                  if (rx_er) err <= 1'b1;
               end
            end
            DROP: begin
               if (!rx_dv) begin
                  state    <= IDLE;
                  err      <= 1'b0;
                  len_cnt  <= '0;
                  pre_cnt  <= '0;
                  hold_vld <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RGMII_RX_FRAMER_STATS_EN
   // Saturating frame statistics driven from the registered status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_good <= '0;
         stat_bad  <= '0;
      end else begin
         if (frame_good && stat_good != '1) stat_good <= stat_good + 16'(1);
         if ((frame_bad || preamble_err) && stat_bad != '1) stat_bad <= stat_bad + 16'(1);
      end
   end
`else
   // statistics counters are not built in this configuration
`endif

endmodule
